// File: rtl/dbus_sramx_bridge_pkg.sv
// rtl/dbus_sramx_bridge_pkg.sv - bus request/response types and FSM state for the dbus-to-sramx bridge
package dbus_sramx_bridge_pkg;

    localparam int DEFAULT_LATENCY = 1;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramx_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } sramx_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } bridge_state_t;

endpackage

// File: rtl/dbus_sramx_bridge.sv
// rtl/dbus_sramx_bridge.sv - single-outstanding core data bus to fixed-latency SRAM port bridge
module dbus_sramx_bridge
    import dbus_sramx_bridge_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output sramx_req_t  dsreq,
    input  sramx_resp_t dsresp
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    bridge_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq.valid) begin
                        cnt      <= CNT_W'(LATENCY - 1);
                        is_write <= |dreq.strobe;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue is combinational so addr_ok and en appear in the request cycle itself.
    always_comb begin
        dresp = '0;
        dsreq = '0;
        if (!reset) begin
            if (state == IDLE && dreq.valid) begin
                dsreq.en    = 1'b1;
                dsreq.wen   = dreq.strobe;
                dsreq.addr  = dreq.addr;
                dsreq.wdata = dreq.data;
                dresp.addr_ok = 1'b1;
            end else if (state == WAIT && cnt == '0) begin
                dresp.data_ok = 1'b1;
                dresp.data    = is_write ? 32'h0 : dsresp.rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && dreq.valid) begin
            assert ($countones(dreq.strobe) <= (1 << dreq.size));
        end
    end

endmodule

// File: tb/tb_dbus_sramx_bridge.sv
// tb/tb_dbus_sramx_bridge.sv - directed self-checking bench for dbus_sramx_bridge
module tb_dbus_sramx_bridge;
    import dbus_sramx_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    dbus_req_t   dreq1, dreq3;
    dbus_resp_t  dresp1, dresp3;
    sramx_req_t  dsreq1, dsreq3;
    sramx_resp_t dsresp1, dsresp3;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [5:0]  ra1, ra3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbus_sramx_bridge #(.LATENCY(1)) u1 (
        .clk(clk), .reset(rst1), .dreq(dreq1), .dresp(dresp1), .dsreq(dsreq1), .dsresp(dsresp1)
    );
    dbus_sramx_bridge #(.LATENCY(3)) u3 (
        .clk(clk), .reset(rst3), .dreq(dreq3), .dresp(dresp3), .dsreq(dsreq3), .dsresp(dsresp3)
    );

    always @(posedge clk) begin
        if (dsreq1.en) begin
            ra1 <= dsreq1.addr[7:2];
            for (int b = 0; b < 4; b++)
                if (dsreq1.wen[b]) mem1[dsreq1.addr[7:2]][8*b +: 8] <= dsreq1.wdata[8*b +: 8];
        end
        if (dsreq3.en) begin
            ra3 <= dsreq3.addr[7:2];
            for (int b = 0; b < 4; b++)
                if (dsreq3.wen[b]) mem3[dsreq3.addr[7:2]][8*b +: 8] <= dsreq3.wdata[8*b +: 8];
        end
    end
    assign dsresp1.rdata = mem1[ra1];
    assign dsresp3.rdata = mem3[ra3];

    function automatic dbus_req_t mk(input logic [31:0] a, input logic [3:0] s,
                                     input logic [31:0] d, input msize_t sz);
        dbus_req_t r;
        r.valid  = 1'b1;
        r.addr   = a;
        r.size   = sz;
        r.strobe = s;
        r.data   = d;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        dreq1 = mk(32'h10, 4'h0, 32'h0, MSIZE4);
        dreq3 = mk(32'h10, 4'h0, 32'h0, MSIZE4);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            n_checks++;
            if ({dsreq1.en, dresp1.addr_ok, dresp1.data_ok} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_l1 cycle %0d: en/addr_ok/data_ok=%b required 000", i,
                         {dsreq1.en, dresp1.addr_ok, dresp1.data_ok});
            end
            n_checks++;
            if ({dsreq3.en, dresp3.addr_ok, dresp3.data_ok} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_l3 cycle %0d: en/addr_ok/data_ok=%b required 000", i,
                         {dsreq3.en, dresp3.addr_ok, dresp3.data_ok});
            end
        end
        cyc();
        rst1 = 1'b0; rst3 = 1'b0;
        dreq1 = '0; dreq3 = '0;
    endtask

    task automatic test_read();
        mem1[4] = 32'hDEAD_BEEF;
        cyc();
        dreq1 = mk(32'h0000_0010, 4'h0, 32'h0, MSIZE4);
        #1;
        n_checks++;
        if ({dsreq1.en, dresp1.addr_ok, dresp1.data_ok, dsreq1.wen} !== 7'b110_0000 ||
            dsreq1.addr !== 32'h10) begin
            n_fail++;
            $display("FAIL read_issue: en/addr_ok/data_ok/wen=%b addr=%h required 1100000 addr=00000010",
                     {dsreq1.en, dresp1.addr_ok, dresp1.data_ok, dsreq1.wen}, dsreq1.addr);
        end
        cyc(); #1;
        n_checks++;
        if ({dsreq1.en, dresp1.addr_ok, dresp1.data_ok} !== 3'b001 || dresp1.data !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_data: en/addr_ok/data_ok=%b data=%h required 001 deadbeef",
                     {dsreq1.en, dresp1.addr_ok, dresp1.data_ok}, dresp1.data);
        end
        cyc();
        dreq1 = '0;
        #1;
        n_checks++;
        if (dresp1.data_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL read_single_pulse: data_ok=%b required 0", dresp1.data_ok);
        end
    endtask

    task automatic test_byte_write();
        mem1[8] = 32'h1122_3344;
        cyc();
        dreq1 = mk(32'h0000_0020, 4'b0100, 32'h00AB_0000, MSIZE1);
        #1;
        n_checks++;
        if (dsreq1.en !== 1'b1 || dsreq1.wen !== 4'b0100 || dsreq1.wdata !== 32'h00AB_0000) begin
            n_fail++;
            $display("FAIL write_issue: en=%b wen=%b wdata=%h required 1 0100 00ab0000",
                     dsreq1.en, dsreq1.wen, dsreq1.wdata);
        end
        cyc(); #1;
        n_checks++;
        if (dsreq1.wen !== 4'b0000 || dresp1.data_ok !== 1'b1 || dresp1.data !== 32'h0) begin
            n_fail++;
            $display("FAIL write_done: wen=%b data_ok=%b data=%h required 0000 1 00000000",
                     dsreq1.wen, dresp1.data_ok, dresp1.data);
        end
        n_checks++;
        if (mem1[8] !== 32'h11AB_3344) begin
            n_fail++;
            $display("FAIL write_mem: mem=%h required 11ab3344", mem1[8]);
        end
        cyc();
        dreq1 = '0;
    endtask

    task automatic test_latency3();
        mem3[5] = 32'hCAFE_F00D;
        cyc();
        dreq3 = mk(32'h0000_0014, 4'h0, 32'h0, MSIZE4);
        #1;
        n_checks++;
        if ({dsreq3.en, dresp3.addr_ok, dresp3.data_ok} !== 3'b110) begin
            n_fail++;
            $display("FAIL l3_issue: en/addr_ok/data_ok=%b required 110",
                     {dsreq3.en, dresp3.addr_ok, dresp3.data_ok});
        end
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            n_checks++;
            if (dsreq3.en !== 1'b0 || dresp3.addr_ok !== 1'b0 || dresp3.data_ok !== (k == 3) ||
                (k == 3 && dresp3.data !== 32'hCAFE_F00D)) begin
                n_fail++;
                $display("FAIL l3_wait T+%0d: en=%b addr_ok=%b data_ok=%b data=%h required 0 0 %0d %s",
                         k, dsreq3.en, dresp3.addr_ok, dresp3.data_ok, dresp3.data, (k == 3),
                         (k == 3) ? "cafef00d" : "any");
            end
        end
        cyc();
        dreq3 = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [0:3];
        exp_data[0] = 32'h1000_0001; exp_data[1] = 32'h2000_0002;
        exp_data[2] = 32'h3000_0003; exp_data[3] = 32'h4000_0004;
        for (int i = 0; i < 4; i++) mem1[16 + i] = exp_data[i];
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c % 2 == 0) dreq1 = mk(32'h40 + 32'(4 * (c / 2)), 4'h0, 32'h0, MSIZE4);
            #1;
            n_checks++;
            if (c % 2 == 0) begin
                if ({dsreq1.en, dresp1.addr_ok, dresp1.data_ok} !== 3'b110 ||
                    dsreq1.addr !== 32'h40 + 32'(4 * (c / 2))) begin
                    n_fail++;
                    $display("FAIL b2b_issue T+%0d: en/addr_ok/data_ok=%b addr=%h required 110 addr=%h",
                             c, {dsreq1.en, dresp1.addr_ok, dresp1.data_ok}, dsreq1.addr,
                             32'h40 + 32'(4 * (c / 2)));
                end
            end else begin
                if ({dsreq1.en, dresp1.addr_ok, dresp1.data_ok} !== 3'b001 ||
                    dresp1.data !== exp_data[c / 2]) begin
                    n_fail++;
                    $display("FAIL b2b_data T+%0d: en/addr_ok/data_ok=%b data=%h required 001 %h",
                             c, {dsreq1.en, dresp1.addr_ok, dresp1.data_ok}, dresp1.data,
                             exp_data[c / 2]);
                end
            end
        end
        cyc();
        dreq1 = '0;
    endtask

    task automatic test_reset_mid_wait();
        mem3[6] = 32'h5555_AAAA;
        mem3[7] = 32'h7777_0707;
        cyc();
        dreq3 = mk(32'h0000_0018, 4'h0, 32'h0, MSIZE4);
        cyc();
        rst3  = 1'b1;
        dreq3 = '0;
        cyc();
        rst3 = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            #1;
            n_checks++;
            if (dresp3.data_ok !== 1'b0 || dsreq3.en !== 1'b0) begin
                n_fail++;
                $display("FAIL abort T+%0d: data_ok=%b en=%b required 0 0", k, dresp3.data_ok, dsreq3.en);
            end
            cyc();
        end
        dreq3 = mk(32'h0000_001C, 4'h0, 32'h0, MSIZE4);
        #1;
        n_checks++;
        if ({dsreq3.en, dresp3.addr_ok} !== 2'b11 || dsreq3.addr !== 32'h1C) begin
            n_fail++;
            $display("FAIL abort_reissue: en/addr_ok=%b addr=%h required 11 0000001c",
                     {dsreq3.en, dresp3.addr_ok}, dsreq3.addr);
        end
        for (int k = 0; k < 3; k++) cyc();
        #1;
        n_checks++;
        if (dresp3.data_ok !== 1'b1 || dresp3.data !== 32'h7777_0707) begin
            n_fail++;
            $display("FAIL abort_reissue_data: data_ok=%b data=%h required 1 77770707",
                     dresp3.data_ok, dresp3.data);
        end
        cyc();
        dreq3 = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        ra1 = '0; ra3 = '0;
        test_reset();
        test_read();
        test_byte_write();
        test_latency3();
        test_back_to_back();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
